// File: rtl/tone_decoder_if.sv
// Tone decoder bus: square-wave input and decoded note outputs.
// master is the decoder side, slave is the tone source / display side.
interface tone_decoder_if #(
  parameter int CNT_W = 13
) ();
  logic             tone_in;
  logic             note_valid;
  logic [2:0]       note_idx;
  logic [7:0]       note_onehot;
  logic             note_start;
  logic [CNT_W-1:0] period;

  modport master (
    input  tone_in,
    output note_valid,
    output note_idx,
    output note_onehot,
    output note_start,
    output period
  );

  modport slave (
    output tone_in,
    input  note_valid,
    input  note_idx,
    input  note_onehot,
    input  note_start,
    input  period
  );
endinterface

// File: rtl/tone_decoder.sv
// Period-measuring note decoder for the piano tone path.
// Locks onto one of 8 scale notes after MATCH_N matching periods.
module tone_decoder #(
  parameter int CNT_W   = 13,
  parameter int TOL     = 16,
  parameter int MATCH_N = 3,
  parameter int TIMEOUT = 4500
) (
  input  logic           clk,
  input  logic           rst,
  tone_decoder_if.master bus
);
  localparam int RUN_W = $clog2(MATCH_N + 1);
  localparam int TABLE [8] = '{
    3817, 3400, 3030, 2865,
    2551, 2272, 2024, 1911
  };
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    SILENT,
    ARMED,
    TRACK,
    LOCKED
  } state_e;

  state_e           state_q;
  logic             s1_q;
  logic             s2_q;
  logic             s3_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] period_q;
  logic [RUN_W-1:0] run_q;
  logic [2:0]       cand_q;
  logic [2:0]       idx_q;
  logic [7:0]       onehot_q;
  logic             valid_q;
  logic             start_q;

  logic             rise;
  logic             timeout;
  logic             hit;
  logic [2:0]       hit_idx;
  logic [2:0]       cand_d;
  logic [RUN_W-1:0] run_d;
  logic             lock;
  logic [CNT_W-1:0] cnt_d;

  assign rise    = s2_q & ~s3_q;
  assign timeout = (cnt_q == CNT_TO);

  // Windows never overlap while TOL < 56, so the first hit is the only one.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (!hit &&
          int'(cnt_q) >= TABLE[i] - TOL &&
          int'(cnt_q) <= TABLE[i] + TOL) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
      end
    end
  end

  always_comb begin
    cand_d = cand_q;
    run_d  = '0;
    if (hit && hit_idx == cand_q) begin
      if (int'(run_q) >= MATCH_N) begin
        run_d = run_q;
      end else begin
        run_d = run_q + RUN_W'(1);
      end
    end else if (hit) begin
      cand_d = hit_idx;
      run_d  = RUN_W'(1);
    end
  end

  assign lock = (int'(run_d) == MATCH_N);

  // Saturate so a long gap can never wrap into a table window.
  assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q
                                    : cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SILENT;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      cnt_q    <= '0;
      period_q <= '0;
      run_q    <= '0;
      cand_q   <= '0;
      idx_q    <= '0;
      onehot_q <= '0;
      valid_q  <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      s1_q    <= bus.tone_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      start_q <= 1'b0;
      unique case (state_q)
        SILENT: begin
          if (rise) begin
            state_q <= ARMED;
            cnt_q   <= CNT_W'(1);
          end
        end
        ARMED, TRACK, LOCKED: begin
          if (rise) begin
            cnt_q    <= CNT_W'(1);
            period_q <= cnt_q;
            run_q    <= run_d;
            cand_q   <= cand_d;
            if (state_q != ARMED && lock) begin
              state_q  <= LOCKED;
              valid_q  <= 1'b1;
              idx_q    <= cand_d;
              onehot_q <= 8'b1 << cand_d;
              start_q  <= (state_q != LOCKED);
            end else begin
              state_q  <= TRACK;
              valid_q  <= 1'b0;
              idx_q    <= '0;
              onehot_q <= '0;
            end
          end else if (timeout) begin
            state_q  <= SILENT;
            cnt_q    <= '0;
            run_q    <= '0;
            cand_q   <= '0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            onehot_q <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= SILENT;
      endcase
    end
  end

  assign bus.note_valid  = valid_q;
  assign bus.note_idx    = idx_q;
  assign bus.note_onehot = onehot_q;
  assign bus.note_start  = start_q;
  assign bus.period      = period_q;
endmodule
